// File: rtl/encoder_pkg.sv
// Shared types for the quadrature encoder front end: decoder states and the
// filtered AB level each state expects to see.
`timescale 1ns/1ps
package encoder_pkg;

   typedef enum logic [2:0] {IDLE, UP1, UP2, UP3, DN1, DN2, DN3, WAIT} state_t;

   localparam logic [1:0] IDLE_AB = 2'b11;
   localparam logic [1:0] UP1_AB  = 2'b01;
   localparam logic [1:0] UP2_AB  = 2'b00;
   localparam logic [1:0] UP3_AB  = 2'b10;
   localparam logic [1:0] DN1_AB  = 2'b10;
   localparam logic [1:0] DN2_AB  = 2'b00;
   localparam logic [1:0] DN3_AB  = 2'b01;

   function automatic logic [1:0] pattern(input state_t s);
      case (s)
         UP1:     pattern = UP1_AB;
         UP2:     pattern = UP2_AB;
         UP3:     pattern = UP3_AB;
         DN1:     pattern = DN1_AB;
         DN2:     pattern = DN2_AB;
         DN3:     pattern = DN3_AB;
         default: pattern = IDLE_AB;
      endcase
   endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser followed by a stability counter; the filtered level
// only follows the pin after DEBOUNCE_CYCLES consecutive differing samples.
`timescale 1ns/1ps
module debounce #(
   parameter int DEBOUNCE_CYCLES = 100
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Async_i,
   output logic Filtered_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sync       <= 2'b11;
         cnt        <= '0;
         Filtered_o <= 1'b1;
      end else begin
         sync <= {sync[0], Async_i};
         if (sync[1] == Filtered_o) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            Filtered_o <= sync[1];
            cnt        <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/encoder_tuning.sv
// Quadrature encoder to saturating DDS tuning word: debounced channels feed a
// detent decoder whose completed cycles step the word up or down.
`timescale 1ns/1ps
module encoder_tuning
   import encoder_pkg::*;
#(
   parameter int WIDTH           = 16,
   parameter int STEP            = 1,
   parameter int INIT            = 0,
   parameter int MAX             = 2**WIDTH - 1,
   parameter int DEBOUNCE_CYCLES = 100
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             EncoderA_i,
   input  logic             EncoderB_i,
   output logic [WIDTH-1:0] TuningWord_o,
   output logic             Changed_o,
   output logic             Direction_o
);

   localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX);
   localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

   logic       a_f, b_f;
   logic [1:0] ab;
   state_t     state, state_n;
   logic       det_up, det_dn;

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
      .Clock(Clock), .Reset(Reset), .Async_i(EncoderA_i), .Filtered_o(a_f));
   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
      .Clock(Clock), .Reset(Reset), .Async_i(EncoderB_i), .Filtered_o(b_f));

   assign ab = {a_f, b_f};

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_n;
   end

   // Single-bit changes always hit the next or previous pattern, so the
   // default arms only catch double changes.
   always_comb begin
      state_n = state;
      det_up  = 1'b0;
      det_dn  = 1'b0;
      if (state == WAIT) begin
         if (ab == IDLE_AB) state_n = IDLE;
      end else if (ab != pattern(state)) begin
         case (state)
            IDLE: if (ab == UP1_AB) state_n = UP1;
                  else if (ab == DN1_AB) state_n = DN1;
                  else state_n = WAIT;
            UP1:  if (ab == UP2_AB) state_n = UP2;
                  else if (ab == IDLE_AB) state_n = IDLE;
                  else state_n = WAIT;
            UP2:  if (ab == UP3_AB) state_n = UP3;
                  else if (ab == UP1_AB) state_n = UP1;
                  else state_n = WAIT;
            UP3:  if (ab == IDLE_AB) begin state_n = IDLE; det_up = 1'b1; end
                  else if (ab == UP2_AB) state_n = UP2;
                  else state_n = WAIT;
            DN1:  if (ab == DN2_AB) state_n = DN2;
                  else if (ab == IDLE_AB) state_n = IDLE;
                  else state_n = WAIT;
            DN2:  if (ab == DN3_AB) state_n = DN3;
                  else if (ab == DN1_AB) state_n = DN1;
                  else state_n = WAIT;
            DN3:  if (ab == IDLE_AB) begin state_n = IDLE; det_dn = 1'b1; end
                  else if (ab == DN2_AB) state_n = DN2;
                  else state_n = WAIT;
            default: state_n = WAIT;
         endcase
      end
   end

   logic [WIDTH:0]   word_ext, up_sum, up_new, dn_new;
   logic [WIDTH-1:0] new_word;

   always_comb begin
      word_ext = {1'b0, TuningWord_o};
      up_sum   = word_ext + STEP_W;
      up_new   = (up_sum > MAX_W) ? MAX_W : up_sum;
      dn_new   = (word_ext < STEP_W) ? '0 : word_ext - STEP_W;
      new_word = det_up ? up_new[WIDTH-1:0] : dn_new[WIDTH-1:0];
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         TuningWord_o <= INIT_W;
         Changed_o    <= 1'b0;
         Direction_o  <= 1'b1;
      end else if (det_up || det_dn) begin
         TuningWord_o <= new_word;
         Changed_o    <= (new_word != TuningWord_o);
         Direction_o  <= det_up;
      end else begin
         Changed_o    <= 1'b0;
      end
   end

endmodule

// File: doc/encoder_tuning.md
# encoder_tuning

Quadrature-encoder front end for the DDS generator. It synchronises and debounces the raw EncoderA/EncoderB pins and decodes full detent cycles. It then steps a saturating tuning word up or down, and that word drives the DDS phase accumulator and the frequency display path. The block sits directly upstream of the DDS core, between the top-level encoder pins and the accumulator's tuning-word input.

## Interface
- WIDTH, 16: tuning-word width in bits.
- STEP, 1: amount added or subtracted per detent.
- INIT, 0: tuning word after reset.
- MAX, 2**WIDTH-1: upper saturation limit. MIN is fixed at 0.
- DEBOUNCE_CYCLES, 100: consecutive stable cycles required before a synchronised level is accepted. Must be ≥ 1.
- Clock  in  1  system clock, 25 MHz nominal.
- Reset  in  1  asynchronous, active-low reset.
- EncoderA_i  in  1  raw encoder channel A, asynchronous, idle high.
- EncoderB_i  in  1  raw encoder channel B, asynchronous, idle high.
- TuningWord_o  out  WIDTH  current tuning word, registered.
- Changed_o  out  1  one-cycle pulse on the edge where TuningWord_o changes value.
- Direction_o  out  1  direction of the last accepted detent: 1 = up, 0 = down. Registered and held.

## Operation
- Synchroniser: two flops per channel, both reset to 1.
- Debounce, per channel:
  - The counter increments while the synchronised level differs from the filtered level.
  - The counter clears to 0 whenever the two levels are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the filtered level takes the synchronised level and the counter clears.
  - The filtered level resets to 1.
- Decoder FSM on the filtered pair AB:
  - States: IDLE, UP1, UP2, UP3, DN1, DN2, DN3, WAIT.
  - Up sequence: 11→01→00→10→11, mapping to IDLE→UP1→UP2→UP3→IDLE.
  - Down sequence: 11→10→00→01→11, mapping to IDLE→DN1→DN2→DN3→IDLE.
  - A single-bit change to the previous state in the sequence steps backward. UP1 or DN1 falling back to 11 returns to IDLE with no count.
  - A detent is accepted only on the transition UP3→IDLE (count up) or DN3→IDLE (count down).
  - A change where both filtered bits differ from the current expected pattern enters WAIT. WAIT stays until AB=11, then goes to IDLE with no count.
  - No change in AB: the state holds.
- Tuning word arithmetic, computed in WIDTH+1 bits:
  - Up: new = min(word+STEP, MAX).
  - Down: new = word−STEP, clamped to 0 if it would be negative.
  - Changed_o pulses only if new ≠ old. At a limit there is no pulse and the word holds.
  - Direction_o updates on every accepted detent, including saturated ones.
- Reset values:
  - TuningWord_o = INIT; Changed_o = 0; Direction_o = 1.
  - FSM = IDLE; debounce counters = 0.
- Reset mid-cycle, e.g. while in UP2, discards the partial detent.
- After reset release, if the pins are not at 11 the FSM leaves IDLE per the rules above. A partial sequence never counts.

## Timing
- Latency: an edge on a raw pin, first sampled at rising edge k, reaches the filtered level at edge k+1+DEBOUNCE_CYCLES.
- For the final edge of a detent, the FSM, TuningWord_o, Changed_o and Direction_o update together at edge k+2+DEBOUNCE_CYCLES.
- Changed_o is high for exactly one cycle per value change.
- Detents separated by ≥ 1 cycle of filtered stability are all counted, with no rate limit beyond debounce.
- Bounce shorter than DEBOUNCE_CYCLES is rejected entirely.
- Simultaneous A and B edges that land in the same debounce window reach the FSM as a double change, so the FSM enters WAIT.

## Structure
- Package encoder_pkg holds:
  - the state enum (IDLE, UP1, UP2, UP3, DN1, DN2, DN3, WAIT);
  - the AB pattern constants (IDLE_AB = 2'b11, etc.).
- Sub-module debounce: one instance per channel, containing the synchroniser, counter and filtered flop. Parameter DEBOUNCE_CYCLES; ports Clock, Reset, Async_i, Filtered_o.
- The FSM and the saturating accumulator stay in encoder_tuning.

## Test plan
- Reset with pins idle, INIT=0 → TuningWord_o=0, Changed_o=0, Direction_o=1, held for 5000 cycles.
- 35 up detents (A↓, B↓, A↑, B↑, 10 µs apart) → 35 Changed_o pulses, word=35, Direction_o=1.
- Then 35 down detents (B↓, A↓, B↑, A↑) → word returns to 0 and Direction_o=0. Each final edge's update occurs exactly DEBOUNCE_CYCLES+2 cycles after its first sampling edge.
- 50-cycle glitches on A (DEBOUNCE_CYCLES=100), plus a partial sequence A↓, B↓, B↑, A↑ → no count, FSM back in IDLE.
- Saturation, MAX=3:
  - 5 up detents → word=3 and only 3 Changed_o pulses.
  - Then a down detent from 0 after reset → word=0, no pulse, Direction_o=0.
- Reset asserted while in UP2, and A and B toggled in the same cycle → word=INIT after reset, FSM in WAIT until AB=11, no count.
